// File: rtl/fft_input_reorder.sv
// fft_input_reorder: buffers an 8-sample real frame in time order and replays it
// as bit-reversed operand pairs (with the trivial W8^0 twiddle) for the first DIT stage.
module fft_input_reorder #(
    parameter int width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] in1,
    output logic [width-1:0] in2,
    output logic [width-1:0] wr,
    output logic [width-1:0] wi,
    output logic [1:0]       pair_idx,
    output logic             frame_last
);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [width-1:0] twiddle_one = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] zero_word   = {width{1'b0}};

    function automatic logic [2:0] bitrev3(input logic [2:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    state_t           state_r;
    logic [2:0]       wcnt_r;
    logic [width-1:0] sample_buf_r [8];

    logic             accept_s;
    logic [1:0]       next_k_s;
    logic [width-1:0] upper_s;
    logic [width-1:0] lower_s;

    // Operands of the pair to load next: pair 0 when leaving LOAD, k+1 while emitting.
    always_comb begin
        accept_s = 1'b0;
        next_k_s = 2'd0;
        if (state_r == LOAD) begin
            accept_s = in_valid && in_ready;
            next_k_s = 2'd0;
        end else begin
            accept_s = 1'b0;
            next_k_s = pair_idx + 2'd1;
        end
        upper_s = sample_buf_r[bitrev3({next_k_s, 1'b0})];
        lower_s = sample_buf_r[bitrev3({next_k_s, 1'b1})];
    end

    // Sample buffer; contents are never cleared, only overwritten by accepted samples.
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            sample_buf_r[wcnt_r] <= in_data;
        end
    end

    // Frame sequencer with registered handshake and operand outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOAD;
            wcnt_r     <= 3'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            in1        <= zero_word;
            in2        <= zero_word;
            wr         <= zero_word;
            wi         <= zero_word;
            pair_idx   <= 2'd0;
            frame_last <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        wcnt_r <= wcnt_r + 3'd1;
                        // Pair 0 uses x0/x4 only, so it can load on the same edge as x7.
                        if (wcnt_r == 3'd7) begin
                            state_r    <= EMIT;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            in1        <= upper_s;
                            in2        <= lower_s;
                            wr         <= twiddle_one;
                            wi         <= zero_word;
                            pair_idx   <= next_k_s;
                            frame_last <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (pair_idx == 2'd3) begin
                            state_r   <= LOAD;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            in1        <= upper_s;
                            in2        <= lower_s;
                            wr         <= twiddle_one;
                            wi         <= zero_word;
                            pair_idx   <= next_k_s;
                            frame_last <= (next_k_s == 2'd3);
                        end
                    end
                end
                default: begin
                    state_r   <= LOAD;
                    wcnt_r    <= 3'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: directed scenarios plus a randomized
// run against a queue-based frame model.
module tb_fft_input_reorder;

    localparam int W = 9;
    localparam int N = 5 + 4 * W;
    typedef logic [W-1:0] s_t;
    typedef s_t frame_t [8];
    typedef logic [N-1:0] ov_t;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    s_t   in_data;
    logic in_ready, out_valid;
    s_t   in1, in2, wr, wi;
    logic [1:0] pair_idx;
    logic frame_last;

    int checks = 0;
    int errors = 0;

    fft_input_reorder #(.width(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .wr(wr), .wi(wi),
        .pair_idx(pair_idx), .frame_last(frame_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Bit reversal of a 3-bit index, by arithmetic.
    function automatic int brev3(int v);
        return ((v % 2) * 4) + (((v / 2) % 2) * 2) + ((v / 4) % 2);
    endfunction

    function automatic ov_t obs();
        return {out_valid, in_ready, pair_idx, frame_last, in1, in2, wr, wi};
    endfunction

    function automatic ov_t pk(bit v, bit r, int k, bit last, int a, int b, int c, int d);
        return {v, r, 2'(k), last, s_t'(a), s_t'(b), s_t'(c), s_t'(d)};
    endfunction

    function automatic string str(ov_t x);
        return $sformatf("v=%b rdy=%b k=%0d last=%b in1=%0d in2=%0d wr=%0d wi=%0d",
                         x[N-1], x[N-2], x[N-3 -: 2], x[N-5],
                         $signed(x[4*W-1 -: W]), $signed(x[3*W-1 -: W]),
                         $signed(x[2*W-1 -: W]), $signed(x[W-1:0]));
    endfunction

    // Offers the 8 samples with random idle gaps; returns on the negedge after the last accept.
    task automatic load_frame(input frame_t f, input int max_gap);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(max_gap)) begin
                in_valid = 1'b0;
                in_data  = s_t'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = f[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        ov_t e;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e = pk(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset: got %s want %s", str(obs()), str(e)); end
        @(negedge clk);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset_idle: got %s want %s", str(obs()), str(e)); end
    endtask

    task automatic test_basic();
        frame_t f = '{s_t'(1), s_t'(2), s_t'(3), s_t'(4), s_t'(5), s_t'(6), s_t'(7), s_t'(8)};
        int e1[4] = '{1, 3, 2, 4};
        int e2[4] = '{5, 7, 6, 8};
        ov_t e;
        out_ready = 1'b1;
        load_frame(f, 0);
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, e1[k], e2[k], 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL basic_k%0d: got %s want %s", k, str(obs()), str(e)); end
            @(negedge clk);
        end
        e = pk(1'b0, 1'b1, 3, 1'b1, 4, 8, 1, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL basic_after: got %s want %s", str(obs()), str(e)); end
    endtask

    task automatic test_stall();
        frame_t f = '{s_t'(1), s_t'(2), s_t'(3), s_t'(4), s_t'(5), s_t'(6), s_t'(7), s_t'(8)};
        int e1[4] = '{1, 3, 2, 4};
        int e2[4] = '{5, 7, 6, 8};
        ov_t e;
        out_ready = 1'b1;
        load_frame(f, 0);
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, e1[k], e2[k], 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL stall_k%0d: got %s want %s", k, str(obs()), str(e)); end
            if (k == 1) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = s_t'(99);
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    checks++;
                    if (obs() !== e) begin errors++; $display("FAIL stall_hold%0d: got %s want %s", h, str(obs()), str(e)); end
                end
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        e = pk(1'b0, 1'b1, 3, 1'b1, 4, 8, 1, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL stall_after: got %s want %s", str(obs()), str(e)); end
    endtask

    task automatic test_negative();
        frame_t f = '{s_t'(-256), s_t'(-1), s_t'(255), s_t'(0), s_t'(-128), s_t'(127), s_t'(1), s_t'(-2)};
        int e1[4] = '{-256, 255, -1, 0};
        int e2[4] = '{-128, 1, 127, -2};
        ov_t e;
        out_ready = 1'b1;
        load_frame(f, 3);
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, e1[k], e2[k], 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL negative_k%0d: got %s want %s", k, str(obs()), str(e)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_load();
        frame_t f = '{s_t'(10), s_t'(11), s_t'(12), s_t'(13), s_t'(14), s_t'(15), s_t'(16), s_t'(17)};
        int e1[4] = '{10, 12, 11, 13};
        int e2[4] = '{14, 16, 15, 17};
        ov_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = s_t'(200 + i);
            @(negedge clk);
        end
        rst = 1'b1; in_data = s_t'(250);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        e = pk(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_load_state: got %s want %s", str(obs()), str(e)); end
        load_frame(f, 1);
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, e1[k], e2[k], 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL rst_load_k%0d: got %s want %s", k, str(obs()), str(e)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_emit();
        frame_t f;
        ov_t e;
        for (int i = 0; i < 8; i++) f[i] = s_t'($urandom);
        out_ready = 1'b1;
        load_frame(f, 0);
        for (int k = 0; k < 3; k++) begin
            e = pk(1'b1, 1'b0, k, 1'b0, int'(f[brev3(2 * k)]), int'(f[brev3(2 * k + 1)]), 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL rst_emit_k%0d: got %s want %s", k, str(obs()), str(e)); end
            if (k < 2) @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_emit_hold: got %s want %s", str(obs()), str(e)); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = pk(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_emit_clear: got %s want %s", str(obs()), str(e)); end
    endtask

    task automatic test_back_to_back();
        frame_t a, b;
        ov_t e;
        for (int i = 0; i < 8; i++) begin
            a[i] = s_t'($urandom);
            b[i] = s_t'($urandom);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = a[i];
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, int'(a[brev3(2 * k)]), int'(a[brev3(2 * k + 1)]), 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL b2b_a_k%0d: got %s want %s", k, str(obs()), str(e)); end
            in_data = s_t'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                checks++;
                if ({out_valid, in_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_gap: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
                end
            end
            in_data = b[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = pk(1'b1, 1'b0, k, k == 3, int'(b[brev3(2 * k)]), int'(b[brev3(2 * k + 1)]), 1, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL b2b_b_k%0d: got %s want %s", k, str(obs()), str(e)); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int  acc[$];
        int  qk[$];
        int  q1[$];
        int  q2[$];
        int  sh1 = 0, sh2 = 0, shk = 0;
        bit  wr_on = 1'b0;
        bit  v, r_rst, r_iv, r_or;
        int  d;
        ov_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            v = (qk.size() != 0);
            e = pk(v, !v, shk, shk == 3, sh1, sh2, wr_on ? 1 : 0, 0);
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL random_c%0d: got %s want %s", c, str(obs()), str(e)); end
            r_rst = ($urandom_range(99) == 0);
            r_iv  = ($urandom_range(9) < 7);
            r_or  = ($urandom_range(9) < 6);
            d     = int'($urandom_range(511)) - 256;
            rst = r_rst; in_valid = r_iv; out_ready = r_or; in_data = s_t'(d);
            if (r_rst) begin
                acc.delete(); qk.delete(); q1.delete(); q2.delete();
                sh1 = 0; sh2 = 0; shk = 0; wr_on = 1'b0;
            end else if (qk.size() == 0) begin
                if (r_iv) begin
                    acc.push_back(d);
                    if (acc.size() == 8) begin
                        for (int k = 0; k < 4; k++) begin
                            qk.push_back(k);
                            q1.push_back(acc[brev3(2 * k)]);
                            q2.push_back(acc[brev3(2 * k + 1)]);
                        end
                        acc.delete();
                    end
                end
            end else if (r_or) begin
                void'(qk.pop_front());
                void'(q1.pop_front());
                void'(q2.pop_front());
            end
            if (qk.size() != 0) begin
                shk = qk[0]; sh1 = q1[0]; sh2 = q2[0]; wr_on = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_negative();
        test_reset_mid_load();
        test_reset_mid_emit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_reorder.md
FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 SHALL have parameter width, default 9: bit width of every sample and twiddle port, signed two's complement, integer format.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  upstream sample present on in_data.
REQ-005 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-006 SHALL have port in_data  input  width  real input sample, natural time order.
REQ-007 SHALL have port out_valid  output  1  butterfly operand set present on outputs.
REQ-008 SHALL have port out_ready  input  1  downstream first-stage butterfly consumes operand set.
REQ-009 SHALL have port in1  output  width  upper butterfly operand, real.
REQ-010 SHALL have port in2  output  width  lower butterfly operand, real.
REQ-011 SHALL have port wr  output  width  twiddle real part.
REQ-012 SHALL have port wi  output  width  twiddle imaginary part.
REQ-013 SHALL have port pair_idx  output  2  index k (0..3) of the current butterfly pair.
REQ-014 SHALL have port frame_last  output  1  high with the pair k=3 of a frame.

Function
REQ-015 SHALL process fixed 8-point real frames feeding the first DIT stage (2-point butterflies with real inputs).
REQ-016 SHALL implement states LOAD and EMIT; reset state LOAD.
REQ-017 In LOAD, in_ready SHALL be 1; out_valid SHALL be 0.
REQ-018 In LOAD, a sample SHALL be accepted when in_valid and in_ready are both 1; it is written to buffer address wcnt (3-bit) and wcnt increments.
REQ-019 in_valid low in LOAD SHALL leave buffer and wcnt unchanged (no write, no toggling).
REQ-020 Acceptance of the 8th sample (wcnt=7) SHALL wrap wcnt to 0 and transition to EMIT at the next edge.
REQ-021 In EMIT, in_ready SHALL be 0; samples offered are not accepted.
REQ-022 Pair k SHALL present in1 = buf[bitrev3(2k)], in2 = buf[bitrev3(2k+1)]: k0=(x0,x4), k1=(x2,x6), k2=(x1,x5), k3=(x3,x7).
REQ-023 in1, in2, wr, wi, pair_idx, frame_last SHALL be registered; pair 0 SHALL be loaded on the same edge that enters EMIT, so out_valid rises exactly 1 cycle after the 8th input handshake.
REQ-024 wr SHALL be 1 and wi SHALL be 0 (W8^0, integer format) for every pair.
REQ-025 All outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 On out_valid and out_ready both 1 with k<3, outputs SHALL advance to pair k+1 at the next edge, out_valid staying 1 (one pair per cycle at full throughput).
REQ-027 On handshake of pair 3 (frame_last=1), state SHALL return to LOAD at the next edge: out_valid 0, in_ready 1.
REQ-028 Data outputs SHALL retain last values when out_valid=0 (no toggling, low power); only out_valid/in_ready change.
REQ-029 No arithmetic; sample values SHALL pass through bit-exact, sign preserved.

Reset
REQ-030 rst=1 SHALL force state LOAD, wcnt=0, pair counter=0, in_ready=1, out_valid=0, in1=in2=wr=wi=0, pair_idx=0, frame_last=0 at the next edge.
REQ-031 rst SHALL override all handshakes in the same cycle, including mid-LOAD and mid-EMIT; a partial frame is discarded.
REQ-032 Buffer contents need not be cleared; they SHALL never reach outputs before 8 new samples are accepted.

Verification
REQ-033 Load x=1..8 continuously, out_ready=1 -> out_valid rises 1 cycle after 8th accept; pairs (1,5),(3,7),(2,6),(4,8), pair_idx 0..3, wr=1, wi=0, frame_last only on (4,8); in_ready 1 the cycle after.
REQ-034 Same frame, out_ready=0 for 3 cycles at pair 1 -> (3,7) held unchanged 3 cycles, then sequence resumes; in_ready stays 0 throughout.
REQ-035 Negative samples -256,-1,255,0,-128,127,1,-2 with gapped in_valid -> pairs (-256,-128),(255,1),(-1,127),(0,-2), bit-exact.
REQ-036 rst asserted after 5 samples, then 8 samples 10..17 -> first pair (10,14); no earlier sample appears.
REQ-037 rst asserted while pair 2 is held -> next cycle out_valid=0, in_ready=1, all data outputs 0.
REQ-038 Two back-to-back frames with in_valid held high during EMIT -> no sample accepted during EMIT; second frame pairs correct.
